// File: rtl/g2_frame_pkg.sv
// Shared types and constants for the g2 frame packer: FSM states, sync/CRC constants
// and a one-byte CRC-8 update step.
package g2_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC0,
    SYNC1,
    SEQ,
    LEN_H,
    LEN_L,
    BIN,
    CSUM
  } state_e;

  localparam logic [7:0] SYNC0_BYTE = 8'hA5;
  localparam logic [7:0] SYNC1_BYTE = 8'h5A;
  localparam logic [7:0] CRC8_POLY  = 8'h07;

  // CRC-8, MSB-first, no reflection: fold one whole byte into the running CRC
  function automatic logic [7:0] crc8_step(input logic [7:0] acc, input logic [7:0] data);
    logic [7:0] c;
    c = acc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/g2_frame_csum.sv
// Trailer accumulator for the g2 frame packer. Default build: two's-complement byte sum.
// With G2_FRAME_CRC_EN defined: CRC-8 (poly 0x07, init 0x00) over the same bytes.
module g2_frame_csum
  import g2_frame_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data_i,
  output logic [7:0] trailer_o
);

  logic [7:0] acc_q, acc_d;

`ifdef G2_FRAME_CRC_EN
  always_comb begin
    acc_d = acc_q;
    if (clear)   acc_d = '0;
    else if (en) acc_d = crc8_step(acc_q, data_i);
  end

  assign trailer_o = acc_q;
`else
  always_comb begin
    acc_d = acc_q;
    if (clear)   acc_d = '0;
    else if (en) acc_d = acc_q + data_i;
  end

  // Negated sum makes SEQ..trailer add up to zero mod 256
  assign trailer_o = (~acc_q) + 8'd1;
`endif

  always_ff @(posedge clk) begin
    if (RST) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/g2_frame_packer.sv
// Packs the g2 bin word stream into framed bytes: A5 5A seq len_h len_l bins(MSB first) trailer.
// Trailer type is selected by G2_FRAME_CRC_EN inside g2_frame_csum (sum when undefined).
//
// Handshake: a word moves when g2V && g2R, a byte moves when txV && txR; while txV is
// high and txR low, txV and txDat hold (all tx outputs decode registered state only).
module g2_frame_packer
  import g2_frame_pkg::*;
#(
  parameter int iSIZE     = 31,
  parameter int NBINS     = 1024,
  parameter int BIN_BYTES = 3
) (
  input  logic           clk,
  input  logic           RST,
  input  logic [iSIZE:0] g2Dat,
  input  logic           g2V,
  output logic           g2R,
  output logic [7:0]     txDat,
  output logic           txV,
  input  logic           txR,
  output logic           frameDone,
  output state_e         dbg_state_o
);

  localparam logic [15:0] NBINS_W   = 16'(NBINS);
  localparam logic [1:0]  LAST_BIDX = 2'(BIN_BYTES - 1);

  state_e         state_q, state_d;
  logic [iSIZE:0] wbuf_q, wbuf_d;
  logic           wvalid_q, wvalid_d;
  logic [1:0]     bidx_q, bidx_d;
  logic [15:0]    wld_q, wld_d;
  logic [15:0]    bcnt_q, bcnt_d;
  logic [7:0]     seq_q, seq_d;
  logic           load;
  logic           csum_clear, csum_en;
  logic [7:0]     trailer;
  logic [1:0]     sel;

  assign sel         = LAST_BIDX - bidx_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d    = state_q;
    wbuf_d     = wbuf_q;
    wvalid_d   = wvalid_q;
    bidx_d     = bidx_q;
    wld_d      = wld_q;
    bcnt_d     = bcnt_q;
    seq_d      = seq_q;
    txV        = 1'b1;
    txDat      = '0;
    frameDone  = 1'b0;
    csum_clear = 1'b0;
    csum_en    = 1'b0;
    // Buffer refills from SYNC0 onward, so the first bin is ready before LEN_L ends
    g2R  = !wvalid_q && (wld_q < NBINS_W) && (state_q != IDLE) && (state_q != CSUM);
    load = g2V && g2R;

    case (state_q)
      IDLE: begin
        txV = 1'b0;
        if (g2V) begin
          state_d    = SYNC0;
          csum_clear = 1'b1;
          wld_d      = '0;
          bcnt_d     = '0;
        end
      end
      SYNC0: begin
        txDat = SYNC0_BYTE;
        if (txR) state_d = SYNC1;
      end
      SYNC1: begin
        txDat = SYNC1_BYTE;
        if (txR) state_d = SEQ;
      end
      SEQ: begin
        txDat = seq_q;
        if (txR) begin
          state_d = LEN_H;
          csum_en = 1'b1;
        end
      end
      LEN_H: begin
        txDat = NBINS_W[15:8];
        if (txR) begin
          state_d = LEN_L;
          csum_en = 1'b1;
        end
      end
      LEN_L: begin
        txDat = NBINS_W[7:0];
        if (txR) begin
          state_d = BIN;
          bidx_d  = '0;
          csum_en = 1'b1;
        end
      end
      BIN: begin
        txV   = wvalid_q;
        txDat = wbuf_q[{sel, 3'b000} +: 8];
        if (wvalid_q && txR) begin
          csum_en = 1'b1;
          if (bidx_q == LAST_BIDX) begin
            wvalid_d = 1'b0;
            bidx_d   = '0;
            bcnt_d   = bcnt_q + 16'd1;
            if (bcnt_q + 16'd1 == NBINS_W) state_d = CSUM;
          end else begin
            bidx_d = bidx_q + 2'd1;
          end
        end
      end
      CSUM: begin
        txDat = trailer;
        if (txR) begin
          frameDone = 1'b1;
          seq_d     = seq_q + 8'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      wbuf_d   = g2Dat;
      wvalid_d = 1'b1;
      wld_d    = wld_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= IDLE;
      wbuf_q   <= '0;
      wvalid_q <= 1'b0;
      bidx_q   <= '0;
      wld_q    <= '0;
      bcnt_q   <= '0;
      seq_q    <= '0;
    end else begin
      state_q  <= state_d;
      wbuf_q   <= wbuf_d;
      wvalid_q <= wvalid_d;
      bidx_q   <= bidx_d;
      wld_q    <= wld_d;
      bcnt_q   <= bcnt_d;
      seq_q    <= seq_d;
    end
  end

  g2_frame_csum u_csum (
    .clk       (clk),
    .RST       (RST),
    .clear     (csum_clear),
    .en        (csum_en),
    .data_i    (txDat),
    .trailer_o (trailer)
  );

endmodule

// File: tb/tb_g2_frame_packer.sv
// Scoreboard bench for g2_frame_packer (NBINS=4, BIN_BYTES=3): directed frames,
// backpressure, starvation, truncation, mid-frame reset and sequence wrap.
module tb_g2_frame_packer;
  import g2_frame_pkg::*;

  localparam int NB = 4;
  localparam int BB = 3;

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] g2Dat;
  logic        g2V;
  logic        g2R;
  logic [7:0]  txDat;
  logic        txV;
  logic        txR;
  logic        frameDone;
  state_e      dbg_state;

  always #5 clk = ~clk;

  g2_frame_packer #(.iSIZE(31), .NBINS(NB), .BIN_BYTES(BB)) dut (
    .clk         (clk),
    .RST         (RST),
    .g2Dat       (g2Dat),
    .g2V         (g2V),
    .g2R         (g2R),
    .txDat       (txDat),
    .txV         (txV),
    .txR         (txR),
    .frameDone   (frameDone),
    .dbg_state_o (dbg_state)
  );

  logic [31:0] in_q[$];
  logic [8:0]  exp_q[$];   // {is_trailer, byte}
  int          n_chk  = 0;
  int          n_fail = 0;
  int          tx_cnt = 0;
  bit          hs_pend = 1'b0;
  bit          rand_bp = 1'b0;
  bit          stall_v = 1'b0;
  logic [7:0]  stall_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sw_crc(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (hs_pend) void'(in_q.pop_front());
    if (in_q.size() > 0) begin
      g2V   = 1'b1;
      g2Dat = in_q[0];
    end else begin
      g2V   = 1'b0;
      g2Dat = '0;
    end
    txR     = rand_bp ? ($urandom_range(0, 9) >= 4) : 1'b1;
    hs_pend = g2V && g2R && !RST;
  endtask

  // Expected frame from a small model; only the first nw words are queued for driving.
  task automatic push_frame(input logic [7:0] s, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3, input int nw);
    logic [31:0] w[4];
    logic [7:0]  body[$];
    logic [7:0]  sum;
    logic [7:0]  crc;
    logic [7:0]  trl;
    w    = '{w0, w1, w2, w3};
    body = {s, 8'h00, 8'h04};
    for (int i = 0; i < 4; i++) begin
      body.push_back(w[i][23:16]);
      body.push_back(w[i][15:8]);
      body.push_back(w[i][7:0]);
    end
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h5A});
    sum = '0;
    crc = '0;
    foreach (body[i]) begin
      exp_q.push_back({1'b0, body[i]});
      sum = sum + body[i];
      crc = sw_crc(crc, body[i]);
    end
`ifdef G2_FRAME_CRC_EN
    trl = crc;
`else
    trl = 8'h00 - sum;
`endif
    exp_q.push_back({1'b1, trl});
    for (int i = 0; i < nw; i++) in_q.push_back(w[i]);
  endtask

  // Hand-written basic frame (seq 0, bins 1..4)
  task automatic push_basic();
    logic [7:0] lit[18];
    logic [7:0] crc;
    lit = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h01, 8'h00,
            8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h04, 8'hF2};
`ifdef G2_FRAME_CRC_EN
    crc = '0;
    for (int i = 2; i < 17; i++) crc = sw_crc(crc, lit[i]);
    lit[17] = crc;
`else
    crc = '0;
`endif
    for (int i = 0; i < 18; i++) exp_q.push_back({(i == 17), lit[i]});
    for (int i = 1; i <= 4; i++) in_q.push_back(32'(i));
  endtask

  task automatic drain(input int lim, input string name);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || in_q.size() > 0) && n < lim) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted byte and checks stall stability.
  always @(negedge clk) begin : monitor
    logic [8:0] e;
    logic       exp_fd;
    if (RST) begin
      stall_v = 1'b0;
    end else begin
      exp_fd = 1'b0;
      if (stall_v) begin
        check("stall_txV", txV, 1'b1);
        check("stall_txDat", txDat, stall_dat);
      end
      if (txV && txR) begin
        tx_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_byte: got %0h expected none at %0t", txDat, $time);
        end else begin
          e      = exp_q.pop_front();
          exp_fd = e[8];
          check("txDat", txDat, e[7:0]);
        end
      end
      check("frameDone", frameDone, exp_fd);
      stall_v   = txV && !txR;
      stall_dat = txDat;
    end
  end

  initial begin
    int n;
    int base;
    RST   = 1'b1;
    g2V   = 1'b0;
    g2Dat = '0;
    txR   = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    check("rst_txV", txV, 1'b0);
    check("rst_g2R", g2R, 1'b0);
    check("rst_txDat", txDat, 8'h00);
    check("rst_frameDone", frameDone, 1'b0);
    check("rst_state", dbg_state, IDLE);

    push_basic();
    drain(500, "basic");

    rand_bp = 1'b1;
    push_frame(8'd1, 32'd1, 32'd2, 32'd3, 32'd4, 4);
    drain(2000, "backpressure");
    rand_bp = 1'b0;

    push_frame(8'd2, 32'd1, 32'd2, 32'd3, 32'd4, 2);
    n = 0;
    while (in_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    check("starve_sync", 32'(in_q.size()), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 2) check("starve_txV", txV, 1'b0);
    end
    in_q.push_back(32'd3);
    in_q.push_back(32'd4);
    drain(500, "starve");

    push_frame(8'd3, 32'hFFC00001, 32'h5, 32'h0, 32'h0, 4);
    drain(500, "truncate");

    base = tx_cnt;
    push_frame(8'd4, 32'd1, 32'd2, 32'd3, 32'd4, 4);
    n = 0;
    while (tx_cnt < base + 9 && n < 300) begin
      tick();
      n++;
    end
    check("midrst_sync", 32'(tx_cnt - base), 32'd9);
    RST     = 1'b1;
    hs_pend = 1'b0;
    g2V     = 1'b0;
    in_q.delete();
    exp_q.delete();
    tick();
    RST = 1'b0;
    check("midrst_txV", txV, 1'b0);
    check("midrst_g2R", g2R, 1'b0);
    check("midrst_state", dbg_state, IDLE);
    push_basic();
    drain(500, "after_reset");

    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 257; k++) push_frame(8'(k), 32'd0, 32'd0, 32'd0, 32'd0, 4);
    drain(20000, "wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
